// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch control: button front-end, run/pause/split FSM,
// split display freeze with hold timer, and lap memory.
module stopwatch_lap_ctrl #(
  parameter int LAPS       = 4,
  parameter int HOLD_TICKS = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_tick,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic [23:0] live_time,
  input  logic [3:0]  lap_rd_idx,
  output logic        count_en,
  output logic        count_clr,
  output logic [23:0] disp_time,
  output logic [23:0] lap_rd_data,
  output logic [3:0]  lap_count,
  output logic        lap_full,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    SPLIT = 2'b11
  } state_t;

  state_t      cur, nxt;
  logic        start_s1, start_s2, start_prev;
  logic        lap_s1, lap_s2, lap_prev;
  logic        start_p, lap_p;
  logic        capture, clear;
  logic [15:0] timer;
  logic [23:0] frozen;
  logic [23:0] mem [LAPS];
  logic [23:0] rd_n;
  logic        room;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_s1   <= 1'b0;
      start_s2   <= 1'b0;
      start_prev <= 1'b0;
      lap_s1     <= 1'b0;
      lap_s2     <= 1'b0;
      lap_prev   <= 1'b0;
    end else begin
      start_s1   <= btn_start;
      start_s2   <= start_s1;
      start_prev <= start_s2;
      lap_s1     <= btn_lap;
      lap_s2     <= lap_s1;
      lap_prev   <= lap_s2;
    end
  end

  // start has priority: a simultaneous lap press is dropped
  assign start_p = start_s2 & ~start_prev;
  assign lap_p   = lap_s2 & ~lap_prev & ~start_p;

  always_comb begin
    nxt     = cur;
    capture = 1'b0;
    clear   = 1'b0;
    unique case (1'b1)
      (cur == IDLE): begin
        if (start_p) nxt = RUN;
      end
      (cur == RUN): begin
        if (start_p) begin
          nxt = PAUSE;
        end else if (lap_p) begin
          nxt     = SPLIT;
          capture = 1'b1;
        end
      end
      (cur == SPLIT): begin
        if (start_p) begin
          nxt = PAUSE;
        end else if (lap_p) begin
          capture = 1'b1;
        end else if (cs_tick &&
                     timer == 16'(HOLD_TICKS - 1)) begin
          nxt = RUN;
        end
      end
      (cur == PAUSE): begin
        if (start_p) begin
          nxt = RUN;
        end else if (lap_p) begin
          nxt   = IDLE;
          clear = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= IDLE;
      count_clr <= 1'b0;
    end else begin
      cur       <= nxt;
      count_clr <= clear;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (nxt != SPLIT || capture) begin
      timer <= '0;
    end else if (cs_tick) begin
      timer <= timer + 16'd1;
    end
  end

  assign room = (lap_count < 4'(LAPS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_count <= '0;
      frozen    <= '0;
      for (int i = 0; i < LAPS; i++) mem[i] <= '0;
    end else if (clear) begin
      lap_count <= '0;
      frozen    <= '0;
      for (int i = 0; i < LAPS; i++) mem[i] <= '0;
    end else if (capture) begin
      frozen <= live_time;
      if (room) begin
        lap_count <= lap_count + 4'd1;
        for (int i = 0; i < LAPS; i++)
          if (lap_count == 4'(i)) mem[i] <= live_time;
      end
    end
  end

  always_comb begin
    rd_n = '0;
    for (int i = 0; i < LAPS; i++)
      if (lap_rd_idx == 4'(i) && 4'(i) < lap_count)
        rd_n = mem[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lap_rd_data <= '0;
    else     lap_rd_data <= rd_n;
  end

  assign count_en  = (cur == RUN || cur == SPLIT) & cs_tick;
  assign disp_time = (cur == SPLIT) ? frozen : live_time;
  assign lap_full  = (lap_count == 4'(LAPS));
  assign state     = cur;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl (LAPS=4, HOLD_TICKS=300).
// Inputs change on negedge; outputs are checked on negedge.
module tb_stopwatch_lap_ctrl;

  logic        clk;
  logic        rst;
  logic        cs_tick;
  logic        btn_start;
  logic        btn_lap;
  logic [23:0] live_time;
  logic [3:0]  lap_rd_idx;
  logic        count_en;
  logic        count_clr;
  logic [23:0] disp_time;
  logic [23:0] lap_rd_data;
  logic [3:0]  lap_count;
  logic        lap_full;
  logic [1:0]  state;

  int checks;
  int failures;

  stopwatch_lap_ctrl #(.LAPS(4), .HOLD_TICKS(300)) dut (
    .clk(clk),
    .rst(rst),
    .cs_tick(cs_tick),
    .btn_start(btn_start),
    .btn_lap(btn_lap),
    .live_time(live_time),
    .lap_rd_idx(lap_rd_idx),
    .count_en(count_en),
    .count_clr(count_clr),
    .disp_time(disp_time),
    .lap_rd_data(lap_rd_data),
    .lap_count(lap_count),
    .lap_full(lap_full),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // set buttons; after three edges the press has taken effect
  task automatic press(input logic s, input logic l);
    btn_start = s;
    btn_lap   = l;
    cyc(3);
  endtask

  task automatic rel();
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    cyc(2);
  endtask

  task automatic lap_at(input logic [23:0] t);
    live_time = t;
    press(1'b0, 1'b1);
    rel();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cs_tick = 1'b1;
    cyc(3);
    #1;
    checks++;
    if (state !== 2'b00) begin
      failures++;
      $display("FAIL rst_state got=%b exp=00", state);
    end
    checks++;
    if (count_en !== 1'b0 || count_clr !== 1'b0) begin
      failures++;
      $display("FAIL rst_en_clr got=%b%b exp=00",
               count_en, count_clr);
    end
    checks++;
    if (lap_count !== 4'd0 || lap_full !== 1'b0 ||
        lap_rd_data !== 24'h0) begin
      failures++;
      $display("FAIL rst_laps cnt=%0d full=%b rd=%h exp=0,0,0",
               lap_count, lap_full, lap_rd_data);
    end
    checks++;
    if (disp_time !== live_time) begin
      failures++;
      $display("FAIL rst_disp got=%h exp=%h",
               disp_time, live_time);
    end
    rst = 1'b0;
    cs_tick = 1'b0;
    cyc(2);
  endtask

  task automatic test_start();
    live_time = 24'h000005;
    btn_start = 1'b1;
    cyc(2);
    checks++;
    if (state !== 2'b00) begin
      failures++;
      $display("FAIL start_early got=%b exp=00", state);
    end
    cyc(1);
    checks++;
    if (state !== 2'b01) begin
      failures++;
      $display("FAIL start_run got=%b exp=01", state);
    end
    cyc(6);
    checks++;
    if (state !== 2'b01) begin
      failures++;
      $display("FAIL start_held got=%b exp=01", state);
    end
    rel();
    cs_tick = 1'b1;
    #1;
    checks++;
    if (count_en !== 1'b1) begin
      failures++;
      $display("FAIL run_en_hi got=%b exp=1", count_en);
    end
    @(negedge clk);
    cs_tick = 1'b0;
    #1;
    checks++;
    if (count_en !== 1'b0 || disp_time !== 24'h000005) begin
      failures++;
      $display("FAIL run_en_lo en=%b disp=%h exp=0,000005",
               count_en, disp_time);
    end
  endtask

  task automatic test_split();
    lap_at(24'h001234);
    live_time = 24'h001240;
    cs_tick = 1'b1;
    #1;
    checks++;
    if (state !== 2'b11 || disp_time !== 24'h001234 ||
        lap_count !== 4'd1) begin
      failures++;
      $display("FAIL split_enter st=%b disp=%h cnt=%0d exp=11,001234,1",
               state, disp_time, lap_count);
    end
    checks++;
    if (count_en !== 1'b1) begin
      failures++;
      $display("FAIL split_en got=%b exp=1", count_en);
    end
    cyc(299);
    checks++;
    if (state !== 2'b11) begin
      failures++;
      $display("FAIL split_hold299 got=%b exp=11", state);
    end
    cyc(1);
    cs_tick = 1'b0;
    #1;
    checks++;
    if (state !== 2'b01 || disp_time !== 24'h001240) begin
      failures++;
      $display("FAIL split_expire st=%b disp=%h exp=01,001240",
               state, disp_time);
    end
  endtask

  task automatic test_laps();
    lap_at(24'h002000);
    lap_at(24'h003000);
    checks++;
    if (lap_count !== 4'd3 || lap_full !== 1'b0) begin
      failures++;
      $display("FAIL laps_three cnt=%0d full=%b exp=3,0",
               lap_count, lap_full);
    end
    lap_at(24'h004000);
    lap_at(24'h005000);
    checks++;
    if (lap_count !== 4'd4 || lap_full !== 1'b1) begin
      failures++;
      $display("FAIL laps_sat cnt=%0d full=%b exp=4,1",
               lap_count, lap_full);
    end
    checks++;
    if (state !== 2'b11 || disp_time !== 24'h005000) begin
      failures++;
      $display("FAIL laps_fifth st=%b disp=%h exp=11,005000",
               state, disp_time);
    end
    lap_rd_idx = 4'd2;
    cyc(1);
    checks++;
    if (lap_rd_data !== 24'h003000) begin
      failures++;
      $display("FAIL rd_idx2 got=%h exp=003000", lap_rd_data);
    end
    lap_rd_idx = 4'd0;
    cyc(1);
    checks++;
    if (lap_rd_data !== 24'h001234) begin
      failures++;
      $display("FAIL rd_idx0 got=%h exp=001234", lap_rd_data);
    end
    lap_rd_idx = 4'd3;
    cyc(1);
    checks++;
    if (lap_rd_data !== 24'h004000) begin
      failures++;
      $display("FAIL rd_idx3 got=%h exp=004000", lap_rd_data);
    end
    lap_rd_idx = 4'd4;
    cyc(1);
    checks++;
    if (lap_rd_data !== 24'h0) begin
      failures++;
      $display("FAIL rd_idx4 got=%h exp=000000", lap_rd_data);
    end
  endtask

  task automatic test_expiry_override();
    live_time = 24'h006000;
    cs_tick = 1'b1;
    cyc(297);
    btn_lap = 1'b1;
    cyc(2);
    checks++;
    if (state !== 2'b11) begin
      failures++;
      $display("FAIL ovr_pre got=%b exp=11", state);
    end
    cyc(1);
    cs_tick = 1'b0;
    checks++;
    if (state !== 2'b11 || disp_time !== 24'h006000 ||
        lap_count !== 4'd4) begin
      failures++;
      $display("FAIL ovr_stay st=%b disp=%h cnt=%0d exp=11,006000,4",
               state, disp_time, lap_count);
    end
    rel();
    cs_tick = 1'b1;
    cyc(299);
    checks++;
    if (state !== 2'b11) begin
      failures++;
      $display("FAIL ovr_restart got=%b exp=11", state);
    end
    cyc(1);
    cs_tick = 1'b0;
    checks++;
    if (state !== 2'b01) begin
      failures++;
      $display("FAIL ovr_expire got=%b exp=01", state);
    end
  endtask

  task automatic test_pause_clear();
    press(1'b1, 1'b0);
    rel();
    cs_tick = 1'b1;
    #1;
    checks++;
    if (state !== 2'b10 || count_en !== 1'b0) begin
      failures++;
      $display("FAIL pause st=%b en=%b exp=10,0", state, count_en);
    end
    cs_tick = 1'b0;
    btn_lap = 1'b1;
    cyc(3);
    cs_tick = 1'b1;
    #1;
    checks++;
    if (state !== 2'b00 || count_clr !== 1'b1 ||
        count_en !== 1'b0) begin
      failures++;
      $display("FAIL clr_pulse st=%b clr=%b en=%b exp=00,1,0",
               state, count_clr, count_en);
    end
    checks++;
    if (lap_count !== 4'd0 || lap_full !== 1'b0) begin
      failures++;
      $display("FAIL clr_cnt cnt=%0d full=%b exp=0,0",
               lap_count, lap_full);
    end
    cyc(1);
    cs_tick = 1'b0;
    checks++;
    if (count_clr !== 1'b0) begin
      failures++;
      $display("FAIL clr_width got=%b exp=0", count_clr);
    end
    rel();
    for (int i = 0; i < 4; i++) begin
      lap_rd_idx = 4'(i);
      cyc(1);
      checks++;
      if (lap_rd_data !== 24'h0) begin
        failures++;
        $display("FAIL clr_rd%0d got=%h exp=000000", i, lap_rd_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    press(1'b1, 1'b0);
    rel();
    lap_at(24'h007000);
    press(1'b1, 1'b0);
    rel();
    press(1'b1, 1'b0);
    rel();
    checks++;
    if (state !== 2'b01 || lap_count !== 4'd1) begin
      failures++;
      $display("FAIL b2b_setup st=%b cnt=%0d exp=01,1",
               state, lap_count);
    end
    live_time = 24'h007777;
    press(1'b1, 1'b1);
    rel();
    lap_rd_idx = 4'd1;
    cyc(1);
    checks++;
    if (state !== 2'b10 || lap_count !== 4'd1 ||
        lap_rd_data !== 24'h0) begin
      failures++;
      $display("FAIL b2b_both st=%b cnt=%0d rd=%h exp=10,1,000000",
               state, lap_count, lap_rd_data);
    end
  endtask

  task automatic test_reset_mid_split();
    press(1'b1, 1'b0);
    rel();
    lap_at(24'h008000);
    live_time = 24'h008100;
    lap_rd_idx = 4'd1;
    cyc(1);
    checks++;
    if (state !== 2'b11 || lap_count !== 4'd2 ||
        lap_rd_data !== 24'h008000) begin
      failures++;
      $display("FAIL mid_setup st=%b cnt=%0d rd=%h exp=11,2,008000",
               state, lap_count, lap_rd_data);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (state !== 2'b00 || lap_count !== 4'd0 ||
        lap_rd_data !== 24'h0 || count_clr !== 1'b0 ||
        disp_time !== 24'h008100) begin
      failures++;
      $display("FAIL mid_rst st=%b cnt=%0d rd=%h clr=%b disp=%h exp=00,0,0,0,008100",
               state, lap_count, lap_rd_data, count_clr, disp_time);
    end
    cyc(1);
    rst = 1'b0;
    lap_rd_idx = 4'd0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      checks++;
      if (count_clr !== 1'b0 || lap_rd_data !== 24'h0) begin
        failures++;
        $display("FAIL post_rst%0d clr=%b rd=%h exp=0,000000",
                 i, count_clr, lap_rd_data);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    cs_tick = 1'b0;
    btn_start = 1'b0;
    btn_lap = 1'b0;
    live_time = 24'h000000;
    lap_rd_idx = 4'd0;
    @(negedge clk);
    test_reset();
    test_start();
    test_split();
    test_laps();
    test_expiry_override();
    test_pause_clear();
    test_back_to_back();
    test_reset_mid_split();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
